sdf_cplx_delay_line: RTL and testbench

//  Complex (I/Q) feedback delay line for SDF FFT butterfly stages; successor to the fixed N-deep shift register.

---
 rtl/fft_dly_pkg.sv | 23 ++
 rtl/sdf_cplx_delay_line_if.sv | 33 +++
 rtl/sdf_dly_ram.sv | 26 ++
 rtl/sdf_cplx_delay_line.sv | 164 ++++++++++++++++
 tb/tb_sdf_cplx_delay_line.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_dly_pkg.sv
// Shared definitions for the SDF complex delay line: FSM encoding, sample type, depth clamp.
package fft_dly_pkg;

    localparam int unsigned CPLX_BW = 16;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [CPLX_BW-1:0] re;
        logic [CPLX_BW-1:0] im;
    } cplx_t;

    // Requested log2 depth limited to the largest supported value
    function automatic int unsigned log2_clamp(input int unsigned log2_req,
                                               input int unsigned log2_max);
        return (log2_req > log2_max) ? log2_max : log2_req;
    endfunction

endpackage

// File: rtl/sdf_cplx_delay_line_if.sv
// Stream, control and status signals of the SDF complex delay line.
interface sdf_cplx_delay_line_if #(
    parameter int unsigned BW        = 16,
    parameter int unsigned MAX_DEPTH = 64
);
    localparam int unsigned LOG2_MAX = $clog2(MAX_DEPTH);

    logic                cfg_load;
    logic [LOG2_MAX:0]   cfg_log2_depth;
    logic                in_valid;
    logic                in_ready;
    logic [BW-1:0]       in_re;
    logic [BW-1:0]       in_im;
    logic                flush;
    logic                out_valid;
    logic [BW-1:0]       out_re;
    logic [BW-1:0]       out_im;
    logic [LOG2_MAX:0]   fill_cnt;
    logic                busy;

    // Sample source / controller side
    modport master (
        output cfg_load, cfg_log2_depth, in_valid, in_re, in_im, flush,
        input  in_ready, out_valid, out_re, out_im, fill_cnt, busy
    );

    // Delay line side
    modport slave (
        input  cfg_load, cfg_log2_depth, in_valid, in_re, in_im, flush,
        output in_ready, out_valid, out_re, out_im, fill_cnt, busy
    );

endinterface

// File: rtl/sdf_dly_ram.sv
// Storage for the delay line: single address port, write on we_i, combinational read.
// The caller registers rdata_o on the same edge as the write, giving read-before-write.
module sdf_dly_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/sdf_cplx_delay_line.sv
// Complex feedback delay line for SDF FFT stages: circular buffer with fill tracking,
// output-valid flag, backpressure during drain and flush.
// Optional run-time depth selection is enabled by defining SDF_DLY_DEPTH_CFG_EN.
module sdf_cplx_delay_line
    import fft_dly_pkg::*;
#(
    parameter int unsigned BW        = 16,
    parameter int unsigned MAX_DEPTH = 64
) (
    input logic                  clk,
    input logic                  reset_n,
    sdf_cplx_delay_line_if.slave bus
);

    localparam int unsigned LOG2_MAX = $clog2(MAX_DEPTH);
    localparam int unsigned AW       = LOG2_MAX;
    localparam int unsigned CW       = LOG2_MAX + 1;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic            out_valid_q, out_valid_d;
    logic [BW-1:0]   out_re_q, out_re_d;
    logic [BW-1:0]   out_im_q, out_im_d;

    logic [CW-1:0]   depth_l2;
    logic [CW-1:0]   depth;
    logic [CW-1:0]   depth_m1;
    logic [AW-1:0]   wp_mask;
    logic [AW-1:0]   wp_next;
    logic [CW:0]     drain_sum;
    logic            accept;
    logic            draining;
    logic            ram_we;
    logic [2*BW-1:0] ram_wdata;
    logic [2*BW-1:0] ram_rdata;

`ifdef SDF_DLY_DEPTH_CFG_EN
    logic [CW-1:0]   depth_l2_q, depth_l2_d;

    // Depth can only change while nothing is stored
    always_comb begin
        depth_l2_d = depth_l2_q;
        if (state_q == ST_IDLE && bus.cfg_load) begin
            depth_l2_d = CW'(log2_clamp(32'(bus.cfg_log2_depth), LOG2_MAX));
        end
    end

    // Depth register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_l2_q <= CW'(LOG2_MAX);
        end else begin
            depth_l2_q <= depth_l2_d;
        end
    end

    assign depth_l2 = depth_l2_q;
`else
    logic unused_cfg;

    assign unused_cfg = bus.cfg_load ^ (^bus.cfg_log2_depth);
    assign depth_l2   = CW'(LOG2_MAX);
`endif

    assign depth    = CW'(1) << depth_l2;
    assign depth_m1 = depth - CW'(1);
    assign wp_mask  = depth_m1[AW-1:0];
    assign wp_next  = (wp_q + AW'(1)) & wp_mask;

    assign draining  = (state_q == ST_DRAIN);
    assign accept    = bus.in_valid & ~draining;
    assign ram_we    = accept | draining;
    // Drain pushes zeros through so stored samples reach the output
    assign ram_wdata = draining ? '0 : {bus.in_re, bus.in_im};
    // While draining, drain_q + fill_q stays at D once real samples start leaving
    assign drain_sum = {1'b0, drain_q} + {1'b0, fill_q};

    sdf_dly_ram #(
        .DW    (2 * BW),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (wp_q),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // FSM, write pointer, fill/drain counters and output capture
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        fill_d      = fill_q;
        drain_d     = drain_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;

        if (draining) begin
            wp_d        = wp_next;
            out_re_d    = ram_rdata[2*BW-1:BW];
            out_im_d    = ram_rdata[BW-1:0];
            out_valid_d = (drain_sum >= {1'b0, depth});
            if (out_valid_d) begin
                fill_d = fill_q - CW'(1);
            end
            if (drain_q == depth_m1) begin
                state_d = ST_IDLE;
                wp_d    = '0;
                fill_d  = '0;
                drain_d = '0;
            end else begin
                drain_d = drain_q + CW'(1);
            end
        end else if (accept) begin
            wp_d        = wp_next;
            out_re_d    = ram_rdata[2*BW-1:BW];
            out_im_d    = ram_rdata[BW-1:0];
            out_valid_d = (fill_q == depth);
            if (fill_q != depth) begin
                fill_d = fill_q + CW'(1);
            end
            state_d = (fill_d == depth) ? ST_RUN : ST_FILL;
        end

        // Same-cycle accept above is kept; drain starts next cycle
        if (bus.flush && (state_q == ST_FILL || state_q == ST_RUN)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wp_q        <= '0;
            fill_q      <= '0;
            drain_q     <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign bus.in_ready  = ~draining;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.fill_cnt  = fill_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdf_cplx_delay_line.sv
// Self-checking bench for sdf_cplx_delay_line: FIFO reference model plus output scoreboard.
module tb_sdf_cplx_delay_line;
    import fft_dly_pkg::*;

    localparam int unsigned BW        = 16;
    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned LOG2_MAX  = 6;

    typedef struct {
        bit    is_real;
        cplx_t d;
    } ent_t;

    typedef struct {
        cplx_t s;
        bit    exp_v;
        cplx_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sdf_cplx_delay_line_if #(.BW(BW), .MAX_DEPTH(MAX_DEPTH)) bus ();

    sdf_cplx_delay_line #(.BW(BW), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ent_t  mq[$];      // reference contents of the delay line, oldest first
    cplx_t sb_q[$];    // scoreboard of expected outputs
    int    m_depth;
    int    m_drain_left;
    int    n_vec = 0;
    int    n_err = 0;
    int    n_out = 0;

    function automatic int eff_depth(input int l2);
`ifdef SDF_DLY_DEPTH_CFG_EN
        return 1 << ((l2 > int'(LOG2_MAX)) ? int'(LOG2_MAX) : l2);
`else
        return MAX_DEPTH;
`endif
    endfunction

    function automatic int model_fill();
        int n = 0;
        foreach (mq[i]) if (mq[i].is_real) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb_q.delete();
        m_depth      = MAX_DEPTH;
        m_drain_left = 0;
    endtask

    // One clock cycle: drive, advance model, clock, compare. Entered and left at posedge+1.
    task automatic cycle(input bit v, input cplx_t s, input bit fl, input bit cl, input int cl2);
        bit          was_idle;
        bit          exp_v;
        bit          moved;
        ent_t        e;
        ent_t        p;
        cplx_t       got;
        logic [31:0] prev;
        bus.in_valid       = v;
        bus.in_re          = s.re;
        bus.in_im          = s.im;
        bus.flush          = fl;
        bus.cfg_load       = cl;
        bus.cfg_log2_depth = 7'(cl2);
        check("in_ready", 32'(bus.in_ready), 32'(m_drain_left == 0));
        prev     = {bus.out_re, bus.out_im};
        exp_v    = 1'b0;
        was_idle = (mq.size() == 0) && (m_drain_left == 0);
        moved    = (m_drain_left > 0) || v;
        if (m_drain_left > 0) begin
            e.is_real = 1'b0;
            e.d       = '0;
            mq.push_back(e);
            if (mq.size() > m_depth) begin
                p = mq.pop_front();
                if (p.is_real) begin
                    exp_v = 1'b1;
                    sb_q.push_back(p.d);
                end
            end
            m_drain_left--;
            if (m_drain_left == 0) mq.delete();
        end else begin
            if (v) begin
                e.is_real = 1'b1;
                e.d       = s;
                mq.push_back(e);
                if (mq.size() > m_depth) begin
                    p     = mq.pop_front();
                    exp_v = 1'b1;
                    sb_q.push_back(p.d);
                end
            end
            if (fl && !was_idle) m_drain_left = m_depth;
            if (cl && was_idle) m_depth = eff_depth(cl2);
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (bus.out_valid) begin
            n_out++;
            if (sb_q.size() == 0) begin
                check("sb_underrun", 32'(1), 32'(0));
            end else begin
                got = sb_q.pop_front();
                check("out_re", 32'(bus.out_re), 32'(got.re));
                check("out_im", 32'(bus.out_im), 32'(got.im));
            end
        end else if (!moved) begin
            check("out_hold", {bus.out_re, bus.out_im}, prev);
        end
        check("fill_cnt", 32'(bus.fill_cnt), 32'(model_fill()));
        check("busy", 32'(bus.busy), 32'((mq.size() != 0) || (m_drain_left != 0)));
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, 1'b0, 1'b0, 0);
    endtask

    task automatic cfg(input int l2);
        cycle(1'b0, '0, 1'b0, 1'b1, l2);
    endtask

    // Flush and run the drain to completion; bounded by the maximum depth
    task automatic flush_all();
        cplx_t r;
        cycle(1'b0, '0, 1'b1, 1'b0, 0);
        for (int i = 0; i < int'(MAX_DEPTH) + 2 && m_drain_left > 0; i++) begin
            r.re = 16'($urandom);
            r.im = 16'($urandom);
            cycle(1'b1, r, 1'b0, 1'b0, 0);   // in_valid must be ignored while draining
        end
    endtask

    vec_t  tbl[10];
    cplx_t s;
    int    d;
    int    n0;

    initial begin
        reset_n            = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_re          = '0;
        bus.in_im          = '0;
        bus.flush          = 1'b0;
        bus.cfg_load       = 1'b0;
        bus.cfg_log2_depth = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out", {bus.out_re, bus.out_im}, 32'(0));
        check("rst_fill", 32'(bus.fill_cnt), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp through a depth-4 line (depth 64 without run-time config)
        d = eff_depth(2);
        for (int k = 0; k < 10; k++) begin
            tbl[k].s.re  = 16'(k + 1);
            tbl[k].s.im  = 16'(-(k + 1));
            tbl[k].exp_v = (k >= d);
            tbl[k].exp.re = 16'(k + 1 - d);
            tbl[k].exp.im = 16'(-(k + 1 - d));
        end
        cfg(2);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, tbl[k].s, 1'b0, 1'b0, 0);
            check("t1_valid", 32'(bus.out_valid), 32'(tbl[k].exp_v));
            if (tbl[k].exp_v) begin
                check("t1_re", 32'(bus.out_re), 32'(tbl[k].exp.re));
                check("t1_im", 32'(bus.out_im), 32'(tbl[k].exp.im));
            end
        end
        repeat (3) idle_cycle();
        for (int k = 11; k <= 14; k++) begin
            s.re = 16'(k);
            s.im = 16'(-k);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end
        flush_all();

        // 2: partial fill then flush
        cfg(3);
        n0 = n_out;
        for (int k = 5; k <= 7; k++) begin
            s.re = 16'(k);
            s.im = 16'(-k);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end
        flush_all();
        check("t2_nout", 32'(n_out - n0), 32'(3));
        check("t2_fill", 32'(bus.fill_cnt), 32'(0));
        check("t2_busy", 32'(bus.busy), 32'(0));

        // 3: random gaps on in_valid
        cfg(2);
        for (int i = 0; i < 220; i++) begin
            s.re = 16'($urandom);
            s.im = 16'($urandom);
            cycle(1'($urandom_range(0, 1)), s, 1'b0, 1'b0, 0);
        end

        // 4: cfg_load while running is ignored; in IDLE an oversize request clamps to max
        cfg(5);
        for (int i = 0; i < 12; i++) begin
            s.re = 16'($urandom);
            s.im = 16'($urandom);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end
        flush_all();
        cfg(7);
        for (int i = 0; i < 70; i++) begin
            s.re = 16'(i + 100);
            s.im = 16'($urandom);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end

        // 5: asynchronous reset in the middle of a drain
        cycle(1'b0, '0, 1'b1, 1'b0, 0);
        repeat (10) idle_cycle();
        check("t5_draining", 32'(bus.in_ready), 32'(0));
        #3 reset_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(bus.out_valid), 32'(0));
        check("t5_out", {bus.out_re, bus.out_im}, 32'(0));
        check("t5_fill", 32'(bus.fill_cnt), 32'(0));
        check("t5_busy", 32'(bus.busy), 32'(0));
        check("t5_in_ready", 32'(bus.in_ready), 32'(1));
        model_reset();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        for (int i = 0; i < 64; i++) begin
            s.re = 16'(i + 500);
            s.im = 16'(i);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end
        check("t5_quiet", 32'(n_out - n0), 32'(0));
        s.re = 16'hbeef;
        s.im = 16'h1234;
        cycle(1'b1, s, 1'b0, 1'b0, 0);
        flush_all();

        // 6: small depth request, then flush together with an accept
        cfg(1);
        for (int i = 0; i < 3; i++) begin
            s.re = 16'(i + 40);
            s.im = 16'(i + 80);
            cycle(1'b1, s, 1'b0, 1'b0, 0);
        end
        s.re = 16'h7fff;
        s.im = 16'h8000;
        cycle(1'b1, s, 1'b1, 1'b0, 0);
        check("t6_fill", 32'(bus.fill_cnt), 32'((m_depth < 4) ? m_depth : 4));
        check("t6_drain", 32'(bus.in_ready), 32'(0));
        for (int i = 0; i < int'(MAX_DEPTH) + 2 && m_drain_left > 0; i++) idle_cycle();
        check("t6_idle", 32'(bus.busy), 32'(0));
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
